// File: rtl/multicycle_control.sv
// ============================================================================
// Module      : multicycle_control
// Description : Moore-style main controller for a multicycle MIPS subset
//               (lw, sw, R-type, beq, addi, j, optional bne).
//               Optional macro MC_BNE_EN adds the BNEEX state for bne.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [2:0] alu_control,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       instr_done,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
`ifdef MC_BNE_EN
        ,
        S_BNEEX   = 4'd12
`endif
    } state_t;

    localparam logic [5:0] C_OP_LW    = 6'b100011;
    localparam logic [5:0] C_OP_SW    = 6'b101011;
    localparam logic [5:0] C_OP_RTYPE = 6'b000000;
    localparam logic [5:0] C_OP_BEQ   = 6'b000100;
    localparam logic [5:0] C_OP_ADDI  = 6'b001000;
    localparam logic [5:0] C_OP_J     = 6'b000010;
`ifdef MC_BNE_EN
    localparam logic [5:0] C_OP_BNE   = 6'b000101;
`endif

    localparam logic [5:0] C_FN_ADD = 6'b100000;
    localparam logic [5:0] C_FN_SUB = 6'b100010;
    localparam logic [5:0] C_FN_AND = 6'b100100;
    localparam logic [5:0] C_FN_OR  = 6'b100101;
    localparam logic [5:0] C_FN_SLT = 6'b101010;

    localparam logic [2:0] C_ALU_ADD = 3'b010;
    localparam logic [2:0] C_ALU_SUB = 3'b110;
    localparam logic [2:0] C_ALU_AND = 3'b000;
    localparam logic [2:0] C_ALU_OR  = 3'b001;
    localparam logic [2:0] C_ALU_SLT = 3'b111;

    state_t     r_state;
    state_t     w_state;
    logic [2:0] w_funct_alu;
    logic       w_funct_legal;
    logic       w_pc_write;
    logic       w_branch;
    logic       w_branch_ne;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:   r_state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        C_OP_LW,
                        C_OP_SW:    r_state <= S_MEMADR;
                        C_OP_RTYPE: r_state <= S_RTYPEEX;
                        C_OP_BEQ:   r_state <= S_BEQEX;
                        C_OP_ADDI:  r_state <= S_ADDIEX;
                        C_OP_J:     r_state <= S_JEX;
`ifdef MC_BNE_EN
                        C_OP_BNE:   r_state <= S_BNEEX;
`endif
                        default:    r_state <= S_FETCH;
                    endcase
                end
                S_MEMADR:  r_state <= (op == C_OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:   r_state <= S_MEMWB;
                S_RTYPEEX: r_state <= S_RTYPEWB;
                S_ADDIEX:  r_state <= S_ADDIWB;
                default:   r_state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        w_funct_alu   = C_ALU_ADD;
        w_funct_legal = 1'b1;
        case (funct)
            C_FN_ADD: w_funct_alu = C_ALU_ADD;
            C_FN_SUB: w_funct_alu = C_ALU_SUB;
            C_FN_AND: w_funct_alu = C_ALU_AND;
            C_FN_OR:  w_funct_alu = C_ALU_OR;
            C_FN_SLT: w_funct_alu = C_ALU_SLT;
            default:  w_funct_legal = 1'b0;
        endcase
    end

    // Reset forces the decode to FETCH so outputs are correct before the edge lands.
    assign w_state = reset ? S_FETCH : r_state;
    assign state_o = w_state;

    always_comb begin
        alu_control = C_ALU_ADD;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        pc_src      = 2'b00;
        iord        = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        instr_done  = 1'b0;
        w_pc_write  = 1'b0;
        w_branch    = 1'b0;
        w_branch_ne = 1'b0;
        case (w_state)
            S_FETCH: begin
                alu_src_b  = 2'b01;
                ir_write   = 1'b1;
                w_pc_write = 1'b1;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                iord = 1'b1;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                mem_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_RTYPEEX: begin
                alu_src_a   = 1'b1;
                alu_control = w_funct_alu;
            end
            S_RTYPEWB: begin
                reg_dst    = 1'b1;
                reg_write  = w_funct_legal;
                instr_done = 1'b1;
            end
            S_BEQEX: begin
                alu_src_a   = 1'b1;
                alu_control = C_ALU_SUB;
                pc_src      = 2'b01;
                w_branch    = 1'b1;
                instr_done  = 1'b1;
            end
`ifdef MC_BNE_EN
            S_BNEEX: begin
                alu_src_a   = 1'b1;
                alu_control = C_ALU_SUB;
                pc_src      = 2'b01;
                w_branch_ne = 1'b1;
                instr_done  = 1'b1;
            end
`endif
            S_ADDIWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_JEX: begin
                pc_src     = 2'b10;
                w_pc_write = 1'b1;
                instr_done = 1'b1;
            end
            default: begin
            end
        endcase
        pc_en = w_pc_write | (w_branch & zero) | (w_branch_ne & ~zero);
    end

endmodule

`default_nettype wire
